// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the CPU data-memory port. It is a word-addressed data RAM
//   behind a valid/ready request/response handshake. The number of wait states
//   between accepting a request and presenting its response is programmable.
//
//   Parameters
//     ADDR_W       width of the byte address on req_addr
//     DEPTH_WORDS  number of 32-bit words stored (power of two)
//     WAIT_STATES  extra cycles between accept and response (0..15)
//     BASE_ADDR    byte address mapped to word 0
//
//   Ports
//     clock      rising-edge clock
//     reset      asynchronous, active-low reset
//     req_valid  request present
//     req_ready  responder can accept a request (IDLE)
//     req_write  1 = store, 0 = load
//     req_addr   byte address
//     req_wdata  store data, byte lanes aligned to the word
//     req_be     store byte enables, bit i = byte lane i
//     rsp_valid  response present (RESP)
//     rsp_ready  CPU accepts the response
//     rsp_rdata  load data (0 for stores)
//     rsp_err    access error (only when DMEM_RESP_ERR_EN is defined)
//     busy       transaction in flight (state != IDLE)
//
//   Build option
//     DMEM_RESP_ERR_EN: when defined, rsp_err flags out-of-range or misaligned
//     accesses, and such accesses are dropped. When not defined, rsp_err is 0,
//     a misaligned address uses its word-truncated index, and an out-of-range
//     access is handled silently.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        wait_cnt;

    // The request is captured at accept; req_* are ignored afterwards.
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic [31:0]       mem [DEPTH_WORDS];

    // Address decode of the captured request.
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word_off;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              access_ok;
    logic              access_err;
    logic              unused_off_lsb;

    always_comb begin
        off      = addr_q - BASE_A;
        word_off = {2'b00, off[ADDR_W-1:2]};
        in_range = (addr_q >= BASE_A) && (word_off < DEPTH_A);
        idx      = off[IDX_W+1:2];
`ifdef DMEM_RESP_ERR_EN
        access_ok  = in_range && (addr_q[1:0] == 2'b00);
        access_err = !access_ok;
`else
        access_ok  = in_range;
        access_err = 1'b0;
`endif
    end

    assign unused_off_lsb = &{1'b0, off[1:0]};

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q     <= req_write;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        be_q     <= req_be;
                        // WAIT with a zero count performs the access on the
                        // next edge, which is the zero-wait-state latency.
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        // The access executes only here, so a store commits
                        // exactly once, on the WAIT->RESP edge.
                        state   <= ST_RESP;
                        rsp_err <= access_err;
                        if (wr_q) begin
                            rsp_rdata <= '0;
                            if (access_ok) begin
                                for (int unsigned b = 0; b < 4; b++) begin
                                    if (be_q[b]) begin
                                        mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                    end
                                end
                            end
                        end else begin
                            rsp_rdata <= access_ok ? mem[idx] : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed-vector bench for dmem_responder. The main instance uses one wait
//   state. A second instance uses zero wait states for the latency case.
//   Expected values are hand-computed constants. Expectations for
//   error-reporting accesses follow DMEM_RESP_ERR_EN.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    // Zero-wait-state instance: shares payload inputs, has its own handshakes.
    logic        req_valid_z;
    logic        rsp_ready_z;
    logic        req_ready_z;
    logic        rsp_valid_z;
    logic [31:0] rsp_rdata_z;
    logic        rsp_err_z;
    logic        busy_z;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .WAIT_STATES (1),
        .BASE_ADDR   (0)
    ) dut (
        .clock     (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .WAIT_STATES (0),
        .BASE_ADDR   (0)
    ) dut_z (
        .clock     (clk),
        .reset     (rst_n),
        .req_valid (req_valid_z),
        .req_ready (req_ready_z),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_z),
        .rsp_ready (rsp_ready_z),
        .rsp_rdata (rsp_rdata_z),
        .rsp_err   (rsp_err_z),
        .busy      (busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One transaction on the main instance. The response is held off for
    // `hold` cycles, during which stability is checked. A competing request
    // is presented on the handshake edge and must not be taken in that cycle.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request after accept; it must have no effect.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h5A5A_5A5A;
        req_be    = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        if (!rsp_valid) return;
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        if (hold > 0) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'hFFFF_FFFF;
            req_be    = 4'hF;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0000;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One transaction on the zero-wait-state instance; response one edge after accept.
    task automatic do_req_z(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        @(negedge clk);
        req_valid_z = 1'b1;
        req_write   = wr;
        req_addr    = addr;
        req_wdata   = wdata;
        req_be      = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid_z = 1'b0;
        check({tag, "_valid_n"}, 32'(rsp_valid_z), 32'd0);
        check({tag, "_busy_n"}, 32'(busy_z), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_n1"}, 32'(rsp_valid_z), 32'd1);
        check({tag, "_rdata"}, rsp_rdata_z, exp_rdata);
        rsp_ready_z = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_z = 1'b0;
        check({tag, "_done"}, 32'(rsp_valid_z), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        rsp_ready   = 1'b0;
        req_valid_z = 1'b0;
        rsp_ready_z = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_rdata",     rsp_rdata, 32'd0);
        check("rst_err",       32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        // Full-word store and load back
        do_req("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        do_req("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);

        // Single-lane store
        do_req("st_lane1", 1'b1, 32'h10, 32'h0000_AB00, 4'b0010, 0, 32'h0, 1'b0);
        do_req("ld_lane1", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_ABEF, 1'b0);

        // No-op store with be=0
        do_req("st_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0);
        do_req("ld_be0", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_ABEF, 1'b0);

        // Backpressured load: held for 5 cycles, single handshake
        do_req("ld_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEAD_ABEF, 1'b0);

        // Misaligned accesses
        do_req("ld_mis", 1'b0, 32'h13, 32'h0, 4'h0, 0,
               ERR_EN ? 32'h0 : 32'hDEAD_ABEF, ERR_EN);
        do_req("st_mis", 1'b1, 32'h12, 32'h1111_1111, 4'hF, 0, 32'h0, ERR_EN);
        do_req("ld_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, 0,
               ERR_EN ? 32'hDEAD_ABEF : 32'h1111_1111, 1'b0);

        // Out-of-range: store dropped, load returns 0, last word intact
        do_req("st_last", 1'b1, 32'h3FC, 32'hAAAA_5555, 4'hF, 0, 32'h0, 1'b0);
        do_req("st_oor", 1'b1, 32'h400, 32'h0000_0001, 4'hF, 0, 32'h0, ERR_EN);
        do_req("ld_oor", 1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, ERR_EN);
        do_req("ld_last", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'hAAAA_5555, 1'b0);
        do_req("ld_word0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        // Reset during WAIT: store discarded, no response
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_after_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_after_ready", 32'(req_ready), 32'd1);
        do_req("ld_rstmid", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        do_req("ld_rst_clr", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        // Zero wait states
        do_req_z("z_st", 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0);
        do_req_z("z_ld", 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
